// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_N = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Operation captured at acceptance; sign bits are already masked for unsigned ops.
    typedef struct packed {
        op_e  op;
        logic neg_a;
        logic neg_b;
    } req_t;

    function automatic logic op_is_div(op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_sign_fix.sv
// Conditional two's-complement: y = neg ? -x : x.
module sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);

    assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int ITER = N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mt_we,
    input  logic         mt_sel,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(ITER + 1);

    state_e         state_q, state_d;
    req_t           req_q;
    logic [N-1:0]   acc_hi, acc_lo, dvsr;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   hi_q, lo_q;
    logic           dz_q;

    // Request decode
    op_e            op_in;
    logic           accept, in_div, in_signed, neg_a, neg_b, div_by_zero;
    logic [N-1:0]   mag_a, mag_b;

    assign op_in       = op_e'(op);
    assign accept      = start_valid && (state_q == S_IDLE);
    assign in_div      = op_is_div(op_in);
    assign in_signed   = op_is_signed(op_in);
    assign neg_a       = in_signed & a[N-1];
    assign neg_b       = in_signed & b[N-1];
    assign div_by_zero = in_div && (b == '0);

    sign_fix #(.N(N)) u_abs_a (.x(a), .neg(neg_a), .y(mag_a));
    sign_fix #(.N(N)) u_abs_b (.x(b), .neg(neg_b), .y(mag_b));

    // One iteration step for each algorithm
    logic [N:0]     mul_sum, div_shift, div_diff;
    logic           last_iter;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvsr} : '0);
    assign div_shift = {acc_hi, acc_lo[N-1]};
    assign div_diff  = div_shift - {1'b0, dvsr};
    assign last_iter = (cnt == CW'(ITER));

    // Sign correction of the finished magnitudes
    logic           is_mul, prod_neg, lo_nz, hi_neg;
    logic [N-1:0]   fix_lo, fix_hi, res_hi;

    assign is_mul   = !op_is_div(req_q.op);
    assign prod_neg = req_q.neg_a ^ req_q.neg_b;
    assign lo_nz    = |acc_lo;
    // A 2N-bit negate only carries into the upper half when the lower half is zero.
    assign hi_neg   = is_mul ? (prod_neg & ~lo_nz) : req_q.neg_a;

    sign_fix #(.N(N)) u_fix_lo (.x(acc_lo), .neg(prod_neg), .y(fix_lo));
    sign_fix #(.N(N)) u_fix_hi (.x(acc_hi), .neg(hi_neg),   .y(fix_hi));

    assign res_hi = (is_mul && prod_neg && lo_nz) ? ~acc_hi : fix_hi;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                start_ready = 1'b1;
                if (accept) state_d = div_by_zero ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_iter) state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and architectural HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
        end else if (accept) begin
            req_q.op    <= op_in;
            req_q.neg_a <= neg_a;
            req_q.neg_b <= neg_b;
            acc_hi      <= '0;
            acc_lo      <= mag_a;
            dvsr        <= mag_b;
            cnt         <= '0;
            dz_q        <= div_by_zero;
            if (div_by_zero) begin
                hi_q <= a;
                lo_q <= '1;
            end
        end else if (state_q == S_CALC) begin
            if (last_iter) begin
                hi_q <= res_hi;
                lo_q <= fix_lo;
            end else begin
                cnt <= cnt + CW'(1);
                if (is_mul) begin
                    acc_hi <= mul_sum[N:1];
                    acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
                end else if (!div_diff[N]) begin
                    acc_hi <= div_diff[N-1:0];
                    acc_lo <= {acc_lo[N-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[N-1:0];
                    acc_lo <= {acc_lo[N-2:0], 1'b0};
                end
            end
        end else if (state_q == S_IDLE && mt_we) begin
            if (mt_sel) hi_q <= a;
            else        lo_q <= a;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each done pulse.
module tb_muldiv_ctrl;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start_valid = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a = '0, b = '0;
    logic         mt_we = 1'b0, mt_sel = 1'b0;
    logic         start_ready, busy, done, div_zero;
    logic [N-1:0] hi, lo;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dz;
        int           acc;
        int           lmin;
        int           lmax;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    muldiv_ctrl #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .mt_we(mt_we), .mt_sel(mt_sel),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: done=1 with no outstanding operation at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                chk({e.name, "_dz"}, 64'(div_zero), 64'(e.dz));
                checks++;
                if ((cyc - e.acc) >= e.lmin && (cyc - e.acc) <= e.lmax) passes++;
                else $display("FAIL %s_latency: got %0d expected %0d..%0d", e.name, cyc - e.acc, e.lmin, e.lmax);
            end
        end
    end

    task automatic wait_idle(input string nm);
        int t = 0;
        @(negedge clk);
        while (!start_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!start_ready) begin
            checks++;
            $display("FAIL %s_timeout: start_ready=%0b expected 1 within 200 cycles", nm, start_ready);
        end
    endtask

    // Issue one operation; acceptance happens on the next rising edge.
    task automatic issue(input string nm, input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic [N-1:0] eh, input logic [N-1:0] el, input logic edz,
                         input int lmin, input int lmax, input bit push);
        exp_t x;
        wait_idle(nm);
        op = o; a = av; b = bv; start_valid = 1'b1;
        if (push) begin
            x.hi = eh; x.lo = el; x.dz = edz; x.acc = cyc + 1;
            x.lmin = lmin; x.lmax = lmax; x.name = nm;
            sb.push_back(x);
        end
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_dz", 64'(div_zero), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(start_ready), 64'h1);

        // MULT -3*5; hi/lo must hold the old (reset) values mid-CALC
        issue("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 33, 1'b1);
        repeat (5) @(negedge clk);
        chk("calc_busy", 64'(busy), 64'h1);
        chk("calc_ready", 64'(start_ready), 64'h0);
        chk("calc_hold_hi", 64'(hi), 64'h0);
        chk("calc_hold_lo", 64'(lo), 64'h0);

        issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 33, 1'b1);
        issue("mult_m1xm1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 33, 33, 1'b1);
        issue("divu_100_7", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 33, 33, 1'b1);
        issue("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33, 1'b1);
        issue("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 33, 1'b1);
        issue("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 33, 33, 1'b1);
        issue("divu_by0", 2'b11, 32'h4D2, 32'h0, 32'h4D2, 32'hFFFFFFFF, 1'b1, 0, 2, 1'b1);
        wait_idle("dz_sticky");
        chk("dz_sticky", 64'(div_zero), 64'h1);
        issue("div_m7_by0", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0, 2, 1'b1);
        issue("divu_5_9", 2'b11, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 33, 33, 1'b1);
        chk("dz_clear", 64'(div_zero), 64'h0);

        // Reset in the middle of a long multiply: no result, everything cleared
        issue("abort", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 1'b0, 0, 0, 1'b0);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_dz", 64'(div_zero), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 64'(start_ready), 64'h1);

        // Move-to writes in IDLE
        mt_we = 1'b1; mt_sel = 1'b1; a = 32'hDEADBEEF;
        @(negedge clk);
        mt_sel = 1'b0; a = 32'hCAFEF00D;
        chk("mthi", 64'(hi), 64'hDEADBEEF);
        @(negedge clk);
        mt_we = 1'b0;
        chk("mtlo", 64'(lo), 64'hCAFEF00D);

        // Write coinciding with acceptance, then during busy: both dropped
        op = 2'b01; a = 32'd2; b = 32'd3; start_valid = 1'b1; mt_we = 1'b1; mt_sel = 1'b1;
        e.hi = 32'h0; e.lo = 32'h6; e.dz = 1'b0; e.acc = cyc + 1; e.lmin = 33; e.lmax = 33; e.name = "multu_2x3";
        sb.push_back(e);
        @(negedge clk);
        start_valid = 1'b0; a = 32'h11111111;
        chk("mt_at_accept", 64'(hi), 64'hDEADBEEF);
        @(negedge clk);
        mt_sel = 1'b0;
        chk("mt_busy_hi", 64'(hi), 64'hDEADBEEF);
        @(negedge clk);
        mt_we = 1'b0;
        chk("mt_busy_lo", 64'(lo), 64'hCAFEF00D);
        wait_idle("final");
        @(negedge clk);

        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL outstanding: %0d results never returned, expected 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
